// File: rtl/im_access_ctrl.sv
// Instruction-memory sequencer: holds the CPU in BOOT while the loader writes,
// then arbitrates fetch reads against loader writes. Optional: IM_FAIRNESS_EN.
module im_access_ctrl #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [63:0]       fetch_pc,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_err,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_gnt,
  input  logic              load_done,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   load_count,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic            fv_q, fv_d;
  logic            ferr_q, ferr_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            run;
  logic            pc_bad;
  logic            force_fetch;

  assign run    = (state_q == RUN);
  assign pc_bad = (fetch_pc[1:0] != 2'b00) ||
                  (fetch_pc[63:ADDR_W+2] != '0);

`ifdef IM_FAIRNESS_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign force_fetch = (starve_q == SW'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (!run || !fetch_req || fetch_gnt)
      starve_d = '0;
    else if (!force_fetch)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  localparam int unused_starve_max = STARVE_MAX;
  assign force_fetch = 1'b0;
`endif

  always_comb begin
    fetch_gnt = run && fetch_req && (!load_req || force_fetch);
    load_gnt  = load_req && !fetch_gnt;
  end

  // Bus is idle while reset is high so a same-cycle write never lands.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      unique case (1'b1)
        load_gnt: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = load_addr;
          mem_wdata = load_data;
        end
        (fetch_gnt && !pc_bad): begin
          mem_en   = 1'b1;
          mem_addr = fetch_pc[ADDR_W+1:2];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    if (!run && load_done) state_d = RUN;
    fv_d   = fetch_gnt;
    ferr_d = fetch_gnt && pc_bad;
    cnt_d  = cnt_q;
    if (load_gnt && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      fv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fv_q    <= fv_d;
      ferr_q  <= ferr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cpu_hold    = !run;
  assign fetch_valid = fv_q;
  assign fetch_err   = ferr_q;
  assign load_count  = cnt_q;
  assign fetch_instr = (fv_q && !ferr_q) ? mem_rdata : '0;

endmodule

// File: doc/im_access_ctrl.md
# im_access_ctrl

Sequencer and arbiter for the single-port 512×32 instruction memory. Shares the memory between the CPU fetch stage (read) and the program loader (write), and holds the CPU in a BOOT phase until loading is done. Sits between the PC/fetch logic and a synchronous-read instruction RAM. Read data returns one cycle after grant.

## Interface
- ADDR_W, 9, word-address width (2^ADDR_W words)
- DATA_W, 32, instruction width
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win (fairness build only)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_req  in  1  fetch request; held until fetch_gnt
- fetch_pc  in  64  byte address; word index = fetch_pc[ADDR_W+1:2]
- fetch_gnt  out  1  fetch accepted this cycle (combinational)
- fetch_valid  out  1  fetch_instr valid (cycle after grant)
- fetch_instr  out  DATA_W  instruction; 0 when fetch_valid=0 or fetch_err=1
- fetch_err  out  1  with fetch_valid: misaligned (pc[1:0]≠0) or out-of-range (pc[63:ADDR_W+2]≠0)
- load_req  in  1  loader write request; held until load_gnt
- load_addr  in  ADDR_W  word address to write
- load_data  in  DATA_W  word to write
- load_gnt  out  1  write accepted this cycle (combinational)
- load_done  in  1  pulse: program loaded, leave BOOT
- cpu_hold  out  1  high in BOOT; fetch stage must stall
- load_count  out  ADDR_W+1  writes accepted since reset, saturating at 2^(ADDR_W+1)-1
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en with mem_we=0

## Operation
- FSM states: BOOT (after reset), RUN.
  - BOOT: only load_req is granted; fetch_gnt=0; cpu_hold=1. load_done → RUN next edge.
  - RUN: both requesters arbitrated; cpu_hold=0. load_done ignored. Only reset returns to BOOT.
- Arbitration (RUN), one grant per cycle at most:
  - Default: loader wins.
  - Fetch wins if only fetch requests.
- Granted fetch with fetch_err condition: no RAM access (mem_en=0). fetch_valid=1 next cycle with fetch_err=1 and fetch_instr=0.
- Granted fetch, legal address: mem_en=1, mem_we=0, mem_addr=fetch_pc[ADDR_W+1:2].
- Granted load: mem_en=1, mem_we=1, mem_addr=load_addr, mem_wdata=load_data; load_count increments (saturating).
- No grant: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
- Write in cycle N+1 to the address fetched in cycle N: fetch returns the old word.

## Timing
- Reset values: state=BOOT, fetch_valid=0, fetch_err=0, fetch_instr=0, cpu_hold=1, load_count=0, starve counter=0, all mem_* = 0.
- fetch_gnt, load_gnt, mem_* are combinational from requests, state and starve counter.
- Fetch latency: grant in cycle N → fetch_valid=1 in N+1, with fetch_instr=mem_rdata (registered valid/err, rdata passed through).
- Back-to-back fetch grants give one result per cycle.
- Reset asserted mid-operation: in-flight fetch is dropped (fetch_valid=0 immediately). A write granted in the reset cycle is not issued (mem_we forced 0 while reset=1).
- load_done and load_req in the same BOOT cycle: the write is granted, then RUN from the next cycle.

## Configuration
- IM_FAIRNESS_EN defined:
  - The starve counter increments each RUN cycle in which fetch_req=1 and fetch_gnt=0.
  - It clears on any fetch grant, and whenever fetch_req=0.
  - When the counter equals STARVE_MAX, fetch wins over a concurrent load_req.
- IM_FAIRNESS_EN undefined:
  - Strict loader priority; the counter is not built.
  - Fetch can starve indefinitely.

## Test plan
- Reset, write 7 words to addresses 0..6 (e.g. 0xF84002A0 at 0), pulse load_done, then fetch pc=0x0 → fetch_valid next cycle, fetch_instr=0xF84002A0; load_count=7; cpu_hold falls the cycle after load_done.
- In BOOT: fetch_req=1 for 10 cycles → fetch_gnt stays 0, cpu_hold=1.
- Fetch pc=0x6 → fetch_err=1, fetch_instr=0, mem_en=0. Fetch pc=0x800 → fetch_err=1.
- RUN, load_req and fetch_req held continuously:
  - with IM_FAIRNESS_EN, STARVE_MAX=4: loader granted 4 cycles, fetch on the 5th, pattern repeats;
  - without it: fetch never granted.
- Fetch addr 3 in cycle N, loader writes 0x12345678 to addr 3 in N+1 → result is the old word; a refetch returns 0x12345678.
- Assert reset the cycle after a fetch grant → fetch_valid=0, state BOOT, load_count=0.
